// File: rtl/sample_pkg.sv
// Shared types and helpers for the run-length sample compressor.
package sample_pkg;

  typedef enum logic [1:0] {
    INIT,
    SINGLE,
    RUN,
    RECOVER
  } state_t;

  // Continuation marker: all ones across the run counter width.
  function automatic logic [63:0] marker_value(input int cntw);
    return (64'd1 << cntw) - 64'd1;
  endfunction

endpackage

// File: rtl/sample_rle_stream_if.sv
// Sample input and tagged-word output streams of the run-length compressor.
interface sample_rle_stream_if #(
  parameter int W    = 16,
  parameter int IDXW = 40
) ();

  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_index;
  logic            out_first;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_first, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_index, out_first, out_valid
  );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; the head is read straight from storage flops and
// forced to zero while empty so the output bus idles at zero.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sample_rle_stream.sv
// Run-length compressor: literals, run counts and continuation markers, each
// tagged with a sample index and a first-of-page flag, buffered in a FIFO.
module sample_rle_stream
  import sample_pkg::*;
#(
  parameter int W        = 16,
  parameter int CNTW     = 16,
  parameter int PAGE_LOG = 15,
  parameter int IDXW     = 40,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  sample_rle_stream_if.slave  bus,
  output logic                overflow_error
);

  typedef struct packed {
    logic            first;
    logic [IDXW-1:0] index;
    logic [W-1:0]    data;
  } entry_t;

  localparam logic [63:0]     MARKER_FULL = marker_value(CNTW);
  localparam logic [W-1:0]    MARKER      = MARKER_FULL[W-1:0];
  localparam logic [CNTW-1:0] CNT_LAST    = CNTW'(MARKER_FULL - 64'd1);

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [IDXW-1:0]     index_q;
  logic [IDXW-1:0]     run_idx_q, run_idx_d;
  logic [IDXW-1:0]     rec_idx_q, rec_idx_d;
  logic [W-1:0]        last_q;
  logic [PAGE_LOG-1:0] page_q;
  logic                first_pend_q;
  logic                overflow_q;

  logic                accept, drop, same, end_page;
  logic                full, empty, push, pop;
  logic [W-1:0]        push_word;
  logic [IDXW-1:0]     push_idx;
  entry_t              push_entry, head_entry;

  assign bus.in_ready = (state_q != RECOVER) && !full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drop         = bus.in_valid && !bus.in_ready;
  assign same         = (bus.in_data == last_q);
  assign end_page     = &page_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_idx_d = run_idx_q;
    rec_idx_d = rec_idx_q;
    push      = 1'b0;
    push_word = bus.in_data;
    push_idx  = index_q;
    case (state_q)
      INIT: begin
        if (accept) begin
          push    = 1'b1;
          state_d = end_page ? INIT : SINGLE;
        end
      end
      SINGLE: begin
        if (accept) begin
          push = 1'b1;
          if (end_page) begin
            state_d = INIT;
          end else if (same) begin
            state_d   = RUN;
            cnt_d     = '0;
            run_idx_d = index_q + IDXW'(1);
          end
        end
      end
      RUN: begin
        if (accept && same) begin
          if (cnt_q == CNT_LAST) begin
            push      = 1'b1;
            push_word = MARKER;
            push_idx  = (cnt_q == '0) ? index_q : run_idx_q;
            cnt_d     = '0;
            run_idx_d = index_q + IDXW'(1);
            if (end_page) state_d = INIT;
          end else begin
            if (cnt_q == '0) run_idx_d = index_q;
            cnt_d = cnt_q + CNTW'(1);
          end
        end else if (accept) begin
          push      = 1'b1;
          push_word = W'(cnt_q);
          push_idx  = run_idx_q;
          rec_idx_d = index_q;
          state_d   = RECOVER;
        end
      end
      RECOVER: begin
        // The sample that broke the run is already in last_q; emit it once space exists.
        if (!full) begin
          push      = 1'b1;
          push_word = last_q;
          push_idx  = rec_idx_q;
          state_d   = end_page ? INIT : SINGLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    push_entry       = '0;
    push_entry.first = first_pend_q;
    push_entry.index = push_idx;
    push_entry.data  = push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      index_q      <= '0;
      page_q       <= '0;
      first_pend_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else if (clear) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      index_q      <= '0;
      page_q       <= '0;
      first_pend_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Dropped samples still advance the index so tags keep the time base.
      if (bus.in_valid) index_q <= index_q + IDXW'(1);
      if (drop)         overflow_q <= 1'b1;
      if (push) begin
        page_q       <= page_q + PAGE_LOG'(1);
        first_pend_q <= end_page;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) last_q <= bus.in_data;
    run_idx_q <= run_idx_d;
    rec_idx_q <= rec_idx_d;
  end

  assign pop = !empty && bus.out_ready;

  sample_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty)
  );

  assign bus.out_valid  = !empty;
  assign bus.out_data   = head_entry.data;
  assign bus.out_index  = head_entry.index;
  assign bus.out_first  = head_entry.first;
  assign overflow_error = overflow_q;

endmodule
